// File: rtl/micro_sequencer_if.sv
// Bundle between the micro-sequencer and its surroundings: instruction byte
// stream, condition-code feedback and the bus/datapath control it drives.
interface micro_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int REG_W  = 2
) ();
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic              instr_ready;
  logic [PC_W-1:0]   m_pc;
  logic              cc_greater;
  logic              cc_equal;
  logic              reg_file_en;
  logic              reg_file_rw;
  logic              alu_en;
  logic [2:0]        alu_op;
  logic              is_imm_active;
  logic              is_branch;
  logic [REG_W-1:0]  reg_src;
  logic [REG_W-1:0]  reg_dst;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   branch_target;
  logic              halted;

  // Sequencer side: consumes the byte stream and flags, drives control.
  modport master (
    input  instr_valid, instr_data, cc_greater, cc_equal,
    output instr_ready, m_pc, reg_file_en, reg_file_rw, alu_en, alu_op,
           is_imm_active, is_branch, reg_src, reg_dst, imm, branch_target,
           halted
  );

  // Environment side: byte source, datapath and write bus.
  modport slave (
    output instr_valid, instr_data, cc_greater, cc_equal,
    input  instr_ready, m_pc, reg_file_en, reg_file_rw, alu_en, alu_op,
           is_imm_active, is_branch, reg_src, reg_dst, imm, branch_target,
           halted
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-CPU control stage: fetches instruction bytes, decodes them and walks
// the micro-phases, driving Moore-only control and latched micro-registers.
module micro_sequencer #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int REG_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  micro_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_READ,
    S_EXEC,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        op_q, op_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic [REG_W-1:0]  src_q, src_d;
  logic              immf_q, immf_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic              br_q, br_d;

  logic              accept;
  logic [2:0]        byte_op;

  // Branch condition lives in the dst field of a BR instruction.
  function automatic logic branch_taken(input logic [1:0] cond,
                                        input logic       gt,
                                        input logic       eq);
    logic t;
    case (cond)
      2'b00:   t = 1'b1;
      2'b01:   t = eq;
      2'b10:   t = gt;
      default: t = ~eq;
    endcase
    return t;
  endfunction

  assign accept  = bus.instr_valid &&
                   ((state_q == S_FETCH0) || (state_q == S_FETCH1));
  assign byte_op = bus.instr_data[7:5];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    immf_d  = immf_q;
    imm_d   = imm_q;
    tgt_d   = tgt_q;
    br_d    = 1'b0;

    case (state_q)
      S_FETCH0: begin
        if (accept) begin
          op_d   = byte_op;
          dst_d  = REG_W'(bus.instr_data[4:3]);
          src_d  = REG_W'(bus.instr_data[2:1]);
          immf_d = bus.instr_data[0];
          pc_d   = pc_q + PC_W'(1);
          if (byte_op == OP_HALT)
            state_d = S_HALT;
          else if ((byte_op == OP_BR) || bus.instr_data[0])
            state_d = S_FETCH1;
          else
            state_d = S_READ;
        end
      end
      S_FETCH1: begin
        if (accept) begin
          imm_d = bus.instr_data;
          if (op_q == OP_BR)
            tgt_d = PC_W'(bus.instr_data);
          pc_d    = pc_q + PC_W'(1);
          state_d = (op_q == OP_BR) ? S_BRANCH : S_EXEC;
        end
      end
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = (op_q == OP_CMP) ? S_FETCH0 : S_WB;
      S_WB:     state_d = S_FETCH0;
      S_BRANCH: begin
        // Not taken leaves m_pc already past the target byte.
        if (branch_taken(dst_q[1:0], bus.cc_greater, bus.cc_equal)) begin
          br_d = 1'b1;
          pc_d = tgt_q;
        end
        state_d = S_FETCH0;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH0;
      pc_q    <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      immf_q  <= 1'b0;
      imm_q   <= '0;
      tgt_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      immf_q  <= immf_d;
      imm_q   <= imm_d;
      tgt_q   <= tgt_d;
      br_q    <= br_d;
    end
  end

  // Moore outputs; is_branch is registered so it shows alongside the new m_pc.
  always_comb begin
    bus.instr_ready   = 1'b0;
    bus.reg_file_en   = 1'b0;
    bus.reg_file_rw   = 1'b0;
    bus.alu_en        = 1'b0;
    bus.alu_op        = 3'b000;
    bus.is_imm_active = 1'b0;
    bus.halted        = 1'b0;
    case (state_q)
      S_FETCH0, S_FETCH1: bus.instr_ready = 1'b1;
      S_READ:   bus.reg_file_en = 1'b1;
      S_EXEC: begin
        bus.alu_en        = 1'b1;
        bus.alu_op        = op_q;
        bus.is_imm_active = immf_q;
      end
      S_WB: begin
        bus.reg_file_en = 1'b1;
        bus.reg_file_rw = 1'b1;
      end
      S_HALT:   bus.halted = 1'b1;
      default:  ;
    endcase
  end

  assign bus.is_branch     = br_q;
  assign bus.m_pc          = pc_q;
  assign bus.reg_src       = src_q;
  assign bus.reg_dst       = dst_q;
  assign bus.imm           = imm_q;
  assign bus.branch_target = tgt_q;

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Control stage of the micro-CPU that fetches instruction bytes over a valid/ready byte stream, decodes them and steps through micro-phases. Each cycle it drives the bus control arguments and micro-register values (`m_pc`, `reg_src`, `reg_dst`, `imm`, `branch_target`) consumed by the downstream write bus / datapath. It reads back the ALU condition codes (`cc_greater`, `cc_equal`) to resolve branches.

## Interface
- `PC_W`, 8, width of `m_pc` / `branch_target`; wraps modulo 2^PC_W
- `DATA_W`, 8, instruction byte and `imm` width
- `REG_W`, 2, register index width (4 registers)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `instr_valid`  in  1  `instr_data` holds a byte
- `instr_data`  in  DATA_W  instruction/immediate byte
- `instr_ready`  out  1  sequencer accepts a byte this cycle
- `m_pc`  out  PC_W  address of next byte to fetch
- `cc_greater`, `cc_equal`  in  1 each  ALU flags from last CMP/SUB
- `reg_file_en`  out  1  register file access this cycle
- `reg_file_rw`  out  1  0 = read, 1 = write
- `alu_en`  out  1  ALU evaluates this cycle
- `alu_op`  out  3  ALU opcode (instruction opcode bits)
- `is_imm_active`  out  1  ALU operand B taken from `imm`
- `is_branch`  out  1  one-cycle pulse: branch taken, `m_pc` loaded
- `reg_src`, `reg_dst`  out  REG_W  decoded register indices
- `imm`  out  DATA_W  latched immediate byte
- `branch_target`  out  PC_W  latched branch target
- `halted`  out  1  HALT executed

## Operation
- Instruction byte: [7:5] opcode, [4:3] dst (cond for branch), [2:1] src, [0] imm flag.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MOV, 101 CMP, 110 BR, 111 HALT.
- States: FETCH0, FETCH1, READ, EXEC, WB, BRANCH, HALT.
- FETCH0: `instr_ready`=1. On accept, latch opcode/dst/src/flag and `m_pc`+1.
  - HALT goes to HALT.
  - BR, or imm flag=1, goes to FETCH1.
  - Otherwise goes to READ.
- FETCH1: `instr_ready`=1. On accept, latch byte into `imm` (and `branch_target` if BR) and `m_pc`+1.
  - BR goes to BRANCH; others go to EXEC.
- READ: `reg_file_en`=1, `reg_file_rw`=0, `reg_src` valid. Goes to EXEC.
- EXEC: `alu_en`=1, `alu_op`=opcode, `is_imm_active`=imm flag.
  - CMP goes to FETCH0; others go to WB.
- WB: `reg_file_en`=1, `reg_file_rw`=1, `reg_dst` valid. Goes to FETCH0.
- BRANCH: cond 00 always, 01 `cc_equal`, 10 `cc_greater`, 11 !`cc_equal`.
  - Taken: `is_branch`=1, `m_pc`<=`branch_target`.
  - Not taken: `m_pc` unchanged (already points past target byte).
  - Goes to FETCH0.
- HALT: all enables 0, `instr_ready`=0, `halted`=1. Leaves only via reset.
- Control outputs not listed for a state are 0. `reg_src`, `reg_dst`, `imm` and `branch_target` hold their last latched values.
- `m_pc` wraps from 2^PC_W-1 to 0. Latched fields are not cleared between instructions.

## Timing
- Outputs are Moore: a function of the registered state and registers only. There is no combinational path from inputs to outputs.
- A byte transfers on the rising edge where `instr_valid`&&`instr_ready`. If valid is low, the state holds, all enables stay 0 and `m_pc` holds.
- Latency with zero fetch stalls:
  - Register ALU op: 4 cycles (FETCH0, READ, EXEC, WB).
  - Immediate ALU op: 4 cycles (FETCH0, FETCH1, EXEC, WB).
  - Register CMP: 3 cycles.
  - BR: 3 cycles.
- `cc_*` are sampled only in BRANCH. The datapath keeps them stable from the prior EXEC.
- Reset (`rst_n`=0 at an edge, any state, including mid-instruction):
  - State goes to FETCH0 and the partial instruction is discarded.
  - `m_pc`, `imm`, `branch_target`, `reg_src`, `reg_dst` and `alu_op` go to 0.
  - All enables, `is_branch` and `halted` go to 0.
  - `instr_ready` goes to 1, because FETCH0 is Moore.

## Test plan
- Reset, then stream 0x0A (ADD dst1, src1, imm=0):
  - READ cycle: `reg_file_en`=1, `reg_file_rw`=0, `reg_src`=1.
  - EXEC cycle: `alu_en`=1, `alu_op`=000.
  - WB cycle: `reg_file_rw`=1, `reg_dst`=1.
  - Back in FETCH0 with `m_pc`=1.
- 0x81 then 0x5A (MOV imm): FETCH1 latches `imm`=0x5A; EXEC has `is_imm_active`=1; WB follows; `m_pc`=2.
- 0xC8, 0x40 (BR eq), `cc_equal`=1:
  - Taken: `is_branch` pulses for 1 cycle and `m_pc`=0x40.
  - Repeat with `cc_equal`=0: `is_branch`=0 and `m_pc`=2.
- `m_pc` preset to 0xFF via BR to 0xFF, then fetch one plain ALU byte: `m_pc` wraps to 0x00.
- Hold `instr_valid` low 5 cycles in FETCH1, then pulse `rst_n` low in EXEC: no state change while stalled; reset gives FETCH0, `m_pc`=0, all enables 0.
- Send 0xE0 (HALT): `halted`=1 and `instr_ready`=0 for 10 further cycles despite `instr_valid`=1. Reset clears `halted`.
